multiplier_4bit_by_2bit_seq: RTL

Sequential shift-and-add multiply-accumulate unit. It rebuilds a dividend from a divider result: result = quotient × divisor + remainder. It sits downstream of the 4-bit by 2-bit divider as its inverse operation, used for self-check and round-trip verification. A valid/ready handshake is provided on both input and output sides.

---
 rtl/multiplier_4bit_by_2bit_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/multiplier_4bit_by_2bit_seq.sv
// Sequential shift-and-add multiply-accumulate: result = quotient * divisor + remainder.
// Inverse of the 4-bit by 2-bit divider; one multiplier bit per cycle, LSB first.
module multiplier_4bit_by_2bit_seq #(
  parameter int unsigned QW = 4,
  parameter int unsigned DW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    quotient,
  input  logic [DW-1:0]    divisor,
  input  logic [DW-1:0]    remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW+DW-1:0] result,
  output logic             rem_err
);

  localparam int unsigned AW = QW + DW;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [QW-1:0]   quotient_q;
  logic [DW-1:0]   divisor_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;
  logic [AW-1:0]   result_q;
  logic [CW-1:0]   cnt_q;
  logic            rem_err_q;
  logic            rem_err_out_q;
  logic            out_valid_q;
  logic [DW-1:0]   div_shift;

  // Partial product for the current multiplier bit, added onto the accumulator.
  always_comb begin
    div_shift = divisor_q >> cnt_q;
    acc_d     = acc_q;
    if (div_shift[0]) begin
      acc_d = acc_q + ({{DW{1'b0}}, quotient_q} << cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      quotient_q    <= '0;
      divisor_q     <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      rem_err_q     <= 1'b0;
      rem_err_out_q <= 1'b0;
      result_q      <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            quotient_q <= quotient;
            divisor_q  <= divisor;
            acc_q      <= {{QW{1'b0}}, remainder};
            rem_err_q  <= (remainder >= divisor);
            cnt_q      <= '0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            result_q      <= acc_d;
            rem_err_out_q <= rem_err_q;
            out_valid_q   <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign rem_err   = rem_err_out_q;

endmodule
